display_scan_scheduler: RTL and testbench
=========================================

Name: display_scan_scheduler

Overview:
- Time-multiplexes a common-anode multi-digit seven-segment display, using the 1 kHz single-cycle strobe from the shared pulse generator as its dwell timebase.
- Selects one digit at a time and drives its anode, hex nibble and decimal point to the downstream segment decoder.
- Inserts an all-anodes-off blanking gap between digits to prevent ghosting.
- Sits between the pulse generator and the hex-to-seven-segment decoder at board top level.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DWELL_TICKS, 4, tick pulses a digit stays lit (1..255)
BLANK_CLKS, 16, clk cycles all anodes are off between digits (1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
tick  in  1  single-cycle strobe from pulse generator
enable  in  1  scan enable; low forces display dark
digit_data  in  4*NUM_DIGITS  nibble i at [4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_mask  in  NUM_DIGITS  1 = digit i kept dark during its slot
anode  out  NUM_DIGITS  active-low anode enables
hex_out  out  4  nibble of currently selected digit
dp_out  out  1  active-low decimal point
scan_idx  out  clog2(NUM_DIGITS)  index of current/next digit
frame_done  out  1  one-cycle pulse after last digit's slot ends

Behaviour:
- Clock: single clk. Reset: synchronous, active-high, on rst.
- All outputs are registered.
- Reset values: anode all 1, hex_out 0, dp_out 1, scan_idx 0, frame_done 0, state IDLE, counters 0.
- rst has priority over every other input. Asserting rst mid-scan returns to IDLE at the next edge.
- States:
  - IDLE: outputs dark. If enable is sampled high, go to BLANK next cycle with scan_idx = 0 and blank_cnt = 0.
  - BLANK: anodes all 1, dp_out 1. blank_cnt increments each clk. Tick pulses are ignored, not counted. After exactly BLANK_CLKS cycles in BLANK, go to DRIVE.
  - On the BLANK->DRIVE edge, the following are captured and held constant for the entire DRIVE slot, so input changes mid-slot are not visible until the next slot:
    - digit_data[scan_idx] into hex_out
    - ~dp_in[scan_idx] into dp_out
    - blank_mask[scan_idx]
  - DRIVE: anode[scan_idx] = 0 unless the captured mask bit is 1, in which case anodes stay all 1 and dp_out is 1. All other anode bits are 1. tick_cnt increments on each tick.
  - DRIVE exit: the edge that samples the DWELL_TICKS-th tick ends the slot. Next state is BLANK, tick_cnt is cleared, and scan_idx advances. At NUM_DIGITS-1, scan_idx wraps to 0 and frame_done is 1 for exactly that one cycle.
- enable sampled low in any state: next state IDLE, outputs dark, scan_idx 0, counters cleared. enable low beats a coincident tick or slot end, and no frame_done is issued.
- Latency: enable first sampled high at edge k. BLANK occupies cycles k..k+BLANK_CLKS-1. anode[0] goes low after edge k+BLANK_CLKS.
- Each digit is lit for DWELL_TICKS tick periods. The scan restarts at digit 0 after any reset or enable drop.
- Counters are wide enough for the maximum parameter values, with no overflow. tick_cnt and blank_cnt never exceed their terminal values.

Test Plan:
- Reset: drive rst 1 for 3 cycles with enable=1 and tick toggling -> anode=4'b1111, hex_out=0, dp_out=1, scan_idx=0, frame_done=0 throughout.
- Basic scan (DWELL_TICKS=2, BLANK_CLKS=3, tick every 10 clks, digit_data=16'h4321, dp_in=4'b0100) -> anode sequence 1111(3 clk), 1110/hex 1, 1111(3), 1101/hex 2, 1111(3), 1011/hex 3/dp_out 0, 1111(3), 0111/hex 4. Each lit slot ends on the 2nd tick. frame_done is a single pulse after digit 3, then the sequence repeats from digit 0.
- Blank mask: blank_mask=4'b0010 -> digit 1 slot has anode=1111 and dp_out=1 but the same duration. scan_idx still steps 0,1,2,3.
- Mid-slot data change: change digit_data[3:0] from 1 to 9 halfway through digit 0's slot -> hex_out stays 1 until the slot ends; the next visit to digit 0 shows 9.
- Enable drop: deassert enable during digit 2's DRIVE, coincident with its final tick -> next cycle anode=1111, scan_idx=0, no frame_done. Re-assert enable -> BLANK_CLKS dark cycles, then digit 0 lights.
- Ticks during blank: pulse tick on every cycle of BLANK -> the following DRIVE slot still lasts a full DWELL_TICKS ticks, counted from DRIVE entry.

Source files
------------

// File: rtl/display_scan_scheduler.sv
// Scan scheduler for a common-anode multi-digit seven-segment display.
// Cycles through the digits with a blanking gap between them and holds each lit for a fixed number of ticks.
module display_scan_scheduler #(
    parameter int NUM_DIGITS  = 4,
    parameter int DWELL_TICKS = 4,
    parameter int BLANK_CLKS  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          enable,
    input  logic [4*NUM_DIGITS-1:0]       digit_data,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [3:0]                    hex_out,
    output logic                          dp_out,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            BLANK_LAST = 8'(BLANK_CLKS - 1);
    localparam logic [7:0]            DWELL_LAST = 8'(DWELL_TICKS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF    = '1;
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              blank_cnt_q, blank_cnt_d;
    logic [7:0]              tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    mask_q, mask_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [3:0]              hex_q, hex_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    // Per-digit fields of the digit about to be driven; out-of-range indices read as zero.
    logic [3:0]              nibble_sel;
    logic                    dp_sel;
    logic                    mask_sel;
    logic [NUM_DIGITS-1:0]   lit_pattern;

    always_comb begin
        nibble_sel = 4'h0;
        dp_sel     = 1'b0;
        mask_sel   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble_sel = digit_data[4*i +: 4];
                dp_sel     = dp_in[i];
                mask_sel   = blank_mask[i];
            end
        end
    end

    assign lit_pattern = ~(ONE_HOT0 << idx_q);

    // NOTE: every variable gets a default before the case so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        anode_d     = anode_q;
        hex_d       = hex_q;
        dp_d        = dp_q;
        fd_d        = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            blank_cnt_d = 8'd0;
            tick_cnt_d  = 8'd0;
            idx_d       = '0;
            mask_d      = 1'b0;
            anode_d     = ALL_OFF;
            hex_d       = 4'h0;
            dp_d        = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = BLANK;
                    blank_cnt_d = 8'd0;
                    tick_cnt_d  = 8'd0;
                    idx_d       = '0;
                    anode_d     = ALL_OFF;
                    dp_d        = 1'b1;
                end

                BLANK: begin
                    anode_d = ALL_OFF;
                    dp_d    = 1'b1;
                    if (blank_cnt_q == BLANK_LAST) begin
                        // Digit fields are frozen here for the whole slot.
                        state_d     = DRIVE;
                        blank_cnt_d = 8'd0;
                        tick_cnt_d  = 8'd0;
                        mask_d      = mask_sel;
                        hex_d       = nibble_sel;
                        if (!mask_sel) begin
                            anode_d = lit_pattern;
                            dp_d    = ~dp_sel;
                        end
                    end else begin
                        blank_cnt_d = blank_cnt_q + 8'd1;
                    end
                end

                DRIVE: begin
                    if (tick) begin
                        if (tick_cnt_q == DWELL_LAST) begin
                            state_d     = BLANK;
                            tick_cnt_d  = 8'd0;
                            blank_cnt_d = 8'd0;
                            anode_d     = ALL_OFF;
                            dp_d        = 1'b1;
                            if (idx_q == LAST_IDX) begin
                                idx_d = '0;
                                fd_d  = 1'b1;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + 8'd1;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    anode_d = ALL_OFF;
                    dp_d    = 1'b1;
                end
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            blank_cnt_q <= 8'd0;
            tick_cnt_q  <= 8'd0;
            idx_q       <= '0;
            mask_q      <= 1'b0;
            anode_q     <= ALL_OFF;
            hex_q       <= 4'h0;
            dp_q        <= 1'b1;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            anode_q     <= anode_d;
            hex_q       <= hex_d;
            dp_q        <= dp_d;
            fd_q        <= fd_d;
        end
    end

    assign anode      = anode_q;
    assign hex_out    = hex_q;
    assign dp_out     = dp_q;
    assign scan_idx   = idx_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: slot-timeline reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_display_scan_scheduler;

    localparam int N = 4;
    localparam int D = 2;
    localparam int B = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             enable;
    logic [4*N-1:0]   digit_data;
    logic [N-1:0]     dp_in;
    logic [N-1:0]     blank_mask;
    logic [N-1:0]     anode;
    logic [3:0]       hex_out;
    logic             dp_out;
    logic [1:0]       scan_idx;
    logic             frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int tph      = 0;

    typedef struct packed {
        logic [N-1:0] an;
        logic [3:0]   hx;
        logic         dp;
    } lit_t;
    lit_t seen[$];
    int   fd_cycles;

    display_scan_scheduler #(
        .NUM_DIGITS (N),
        .DWELL_TICKS(D),
        .BLANK_CLKS (B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .enable    (enable),
        .digit_data(digit_data),
        .dp_in     (dp_in),
        .blank_mask(blank_mask),
        .anode     (anode),
        .hex_out   (hex_out),
        .dp_out    (dp_out),
        .scan_idx  (scan_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: a slot is B dark cycles followed by a lit phase lasting D ticks.
    bit           m_on, m_lit, m_mask, m_dp;
    int           m_idx, m_age, m_ticks;
    logic [3:0]   m_hex;
    logic [N-1:0] exp_anode;
    logic [3:0]   exp_hex;
    logic         exp_dp, exp_fd;
    logic [1:0]   exp_idx;

    task automatic model_step();
        exp_fd = 1'b0;
        if (rst || !enable) begin
            m_on = 0; m_lit = 0; m_idx = 0; m_age = 0; m_ticks = 0; m_hex = 4'h0; m_mask = 0;
        end else if (!m_on) begin
            m_on = 1; m_lit = 0; m_idx = 0; m_age = 0; m_ticks = 0;
        end else if (!m_lit) begin
            m_age++;
            if (m_age == B) begin
                m_lit   = 1;
                m_ticks = 0;
                m_hex   = digit_data[4*m_idx +: 4];
                m_dp    = dp_in[m_idx];
                m_mask  = blank_mask[m_idx];
            end
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == D) begin
                exp_fd = (m_idx == N - 1);
                m_idx  = (m_idx + 1) % N;
                m_lit  = 0;
                m_age  = 0;
            end
        end
        exp_anode = '1;
        if (m_lit && !m_mask) exp_anode[m_idx] = 1'b0;
        exp_dp  = !(m_lit && !m_mask && m_dp);
        exp_hex = m_hex;
        exp_idx = 2'(m_idx);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        check("anode", anode, exp_anode);
        check("hex_out", hex_out, exp_hex);
        check("dp_out", dp_out, exp_dp);
        check("scan_idx", scan_idx, exp_idx);
        check("frame_done", frame_done, exp_fd);
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic periodic_tick();
        tick = (tph % 10 == 9);
        tph++;
    endtask

    // Runs periodic ticks until the display goes dark and then shows the given anode pattern.
    task automatic drive_until_lit(input logic [N-1:0] pattern);
        int  budget = 600;
        bit  went_dark = 0;
        while (budget > 0) begin
            if (!went_dark && anode == '1) went_dark = 1;
            if (went_dark && anode == pattern) break;
            periodic_tick();
            next_cycle();
            budget--;
        end
        if (budget == 0) check("wait_lit_timeout", anode, pattern);
    endtask

    // Records each newly lit slot until a frame_done has been seen and the next slot lights.
    task automatic collect_frame();
        int budget = 1200;
        bit prev_dark = (anode == '1);
        seen.delete();
        fd_cycles = 0;
        while (budget > 0) begin
            if (frame_done) fd_cycles++;
            if (anode != '1 && prev_dark) begin
                seen.push_back('{an: anode, hx: hex_out, dp: dp_out});
                if (fd_cycles > 0) break;
            end
            prev_dark = (anode == '1);
            periodic_tick();
            next_cycle();
            budget--;
        end
        if (budget == 0) check("collect_timeout", fd_cycles, 1);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        tick       = 1'b0;
        digit_data = 16'h4321;
        dp_in      = 4'b0100;
        blank_mask = 4'b0000;

        // Reset held with enable high and tick toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_anode", anode, 4'b1111);
            check("rst_hex", hex_out, 4'h0);
            check("rst_dp", dp_out, 1'b1);
            check("rst_idx", scan_idx, 2'd0);
            check("rst_fd", frame_done, 1'b0);
            tick = ~tick;
        end
        rst  = 1'b0;
        tick = 1'b0;

        // First blank gap then digit 0.
        for (int i = 0; i < B; i++) begin
            next_cycle();
            check("start_blank_anode", anode, 4'b1111);
        end
        next_cycle();
        check("d0_anode", anode, 4'b1110);
        check("d0_hex", hex_out, 4'h1);
        check("d0_dp", dp_out, 1'b1);

        // One full frame from digit 0.
        collect_frame();
        check("frame_len", seen.size(), 4);
        if (seen.size() == 4) begin
            check("f_d1_anode", seen[0].an, 4'b1101);
            check("f_d1_hex", seen[0].hx, 4'h2);
            check("f_d2_anode", seen[1].an, 4'b1011);
            check("f_d2_hex", seen[1].hx, 4'h3);
            check("f_d2_dp", seen[1].dp, 1'b0);
            check("f_d3_anode", seen[2].an, 4'b0111);
            check("f_d3_hex", seen[2].hx, 4'h4);
            check("f_wrap_anode", seen[3].an, 4'b1110);
            check("f_wrap_hex", seen[3].hx, 4'h1);
        end
        check("fd_width", fd_cycles, 1);

        // Data change mid-slot stays invisible until the next visit.
        repeat (5) begin periodic_tick(); next_cycle(); end
        digit_data = 16'h4329;
        repeat (3) begin periodic_tick(); next_cycle(); end
        check("mid_anode", anode, 4'b1110);
        check("mid_hex_held", hex_out, 4'h1);
        drive_until_lit(4'b1110);
        check("revisit_hex", hex_out, 4'h9);

        // Masked digit 1 stays dark for its slot.
        blank_mask = 4'b0010;
        collect_frame();
        check("mask_len", seen.size(), 3);
        if (seen.size() == 3) begin
            check("mask_first", seen[0].an, 4'b1011);
            check("mask_second", seen[1].an, 4'b0111);
            check("mask_wrap", seen[2].an, 4'b1110);
        end
        blank_mask = 4'b0000;

        // Enable drop coincident with digit 2's final tick.
        drive_until_lit(4'b1011);
        tick = 1'b1; next_cycle();
        tick = 1'b0; next_cycle();
        check("drop_still_lit", anode, 4'b1011);
        tick = 1'b1; enable = 1'b0; next_cycle();
        check("drop_anode", anode, 4'b1111);
        check("drop_idx", scan_idx, 2'd0);
        check("drop_fd", frame_done, 1'b0);

        // Re-enable with ticks on every blank cycle.
        enable = 1'b1;
        for (int i = 0; i < B; i++) begin
            next_cycle();
            check("reen_blank_anode", anode, 4'b1111);
            check("reen_fd", frame_done, 1'b0);
        end
        next_cycle();
        check("reen_d0_anode", anode, 4'b1110);
        check("reen_d0_idx", scan_idx, 2'd0);
        check("reen_d0_hex", hex_out, 4'h9);
        tick = 1'b0;
        repeat (3) next_cycle();
        tick = 1'b1; next_cycle();
        tick = 1'b0; next_cycle();
        check("blank_ticks_ignored", anode, 4'b1110);
        tick = 1'b1; next_cycle();
        check("dwell_end_anode", anode, 4'b1111);
        check("dwell_end_idx", scan_idx, 2'd1);
        tick = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(199) == 0);
            enable = ($urandom_range(79) != 0);
            tick   = ($urandom_range(3) == 0);
            if ($urandom_range(29) == 0) digit_data = 16'($urandom);
            if ($urandom_range(29) == 0) dp_in      = 4'($urandom);
            if ($urandom_range(29) == 0) blank_mask = 4'($urandom);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
